// File: rtl/vertex_post_processor_if.sv
// Handshake and data bundle between a vertex producer and vertex_post_processor.
// The producer side uses master and the post-processor uses slave.
interface vertex_post_processor_if #(
    parameter int DATAWIDTH     = 18,
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
);
    logic [3:0][DATAWIDTH-1:0]          i_vertex;
    logic                               i_dv;
    logic                               o_ready;
    logic                               i_ready;
    logic [$clog2(SCREEN_WIDTH)-1:0]    o_sx;
    logic [$clog2(SCREEN_HEIGHT)-1:0]   o_sy;
    logic signed [DATAWIDTH-1:0]        o_z;
    logic                               o_clipped;
    logic                               o_dv;

    modport master (
        output i_vertex, i_dv, i_ready,
        input  o_ready, o_sx, o_sy, o_z, o_clipped, o_dv
    );

    modport slave (
        input  i_vertex, i_dv, i_ready,
        output o_ready, o_sx, o_sy, o_z, o_clipped, o_dv
    );
endinterface

// File: rtl/vertex_post_processor.sv
// Clip-space vertex to screen-space pixel: reciprocal of w, perspective divide,
// viewport mapping and NDC-cube clipping, one vertex in flight at a time.
//
// state    | meaning
// IDLE     | o_ready=1, waiting for i_dv
// DIV      | restoring divider, one quotient bit of 2^(2F)/w per cycle
// SCALE    | x,y,z multiplied by saturated reciprocal
// VIEWPORT | NDC mapped to pixel coordinates, clip flag computed
// DONE     | o_dv=1, results held until i_ready
module vertex_post_processor #(
    parameter int DATAWIDTH     = 18,
    parameter int FRACBITS      = 12,
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic                    clk,
    input  logic                    rst,
    vertex_post_processor_if.slave  vif
);
    localparam int DIV_STEPS = 2 * FRACBITS + 1;
    localparam int QW        = DIV_STEPS;
    localparam int CW        = $clog2(DIV_STEPS);
    localparam int RW        = DATAWIDTH + 1;
    localparam int PW        = 2 * DATAWIDTH;
    localparam int SXW       = $clog2(SCREEN_WIDTH);
    localparam int SYW       = $clog2(SCREEN_HEIGHT);
    localparam int SAT_MAX   = 2 ** (DATAWIDTH - 1) - 1;

    localparam logic signed [DATAWIDTH-1:0] ONE_N   = DATAWIDTH'(2 ** FRACBITS);
    localparam logic signed [DATAWIDTH-1:0] RECIP_MAX = DATAWIDTH'(SAT_MAX);
    localparam logic signed [39:0]          ONE_40  = 40'(2 ** FRACBITS);
    localparam logic signed [39:0]          HALF_W  = 40'(SCREEN_WIDTH / 2);
    localparam logic signed [39:0]          HALF_H  = 40'(SCREEN_HEIGHT / 2);

    typedef enum logic [2:0] {IDLE, DIV, SCALE, VIEWPORT, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]                div_cnt;
    logic [RW-1:0]                rem;
    logic [QW-1:0]                quot;
    logic [DATAWIDTH-1:0]         divisor;
    logic signed [DATAWIDTH-1:0]  cx, cy, cz;
    logic signed [DATAWIDTH-1:0]  nx, ny, nz;
    logic [SXW-1:0]               sx_q;
    logic [SYW-1:0]               sy_q;
    logic signed [DATAWIDTH-1:0]  z_q;
    logic                         clipped_q;

    logic                         accept;
    logic                         w_nonpos;
    logic [RW-1:0]                rem_shift;
    logic                         rem_ge;
    logic [RW-1:0]                rem_next;
    logic signed [DATAWIDTH-1:0]  recip;
    logic signed [39:0]           vx, vy;
    logic                         clip_any;

    function automatic logic signed [DATAWIDTH-1:0] scale_sat(
        input logic signed [DATAWIDTH-1:0] c,
        input logic signed [DATAWIDTH-1:0] r
    );
        logic signed [PW-1:0] p;
        p = PW'(c) * PW'(r);
        p = p >>> FRACBITS;
        if (!p[PW-1] && (|p[PW-2:DATAWIDTH-1]))
            return {1'b0, {(DATAWIDTH-1){1'b1}}};
        if (p[PW-1] && !(&p[PW-2:DATAWIDTH-1]))
            return {1'b1, {(DATAWIDTH-1){1'b0}}};
        return p[DATAWIDTH-1:0];
    endfunction

    function automatic logic [15:0] vp_clamp(input logic signed [39:0] v, input int dim);
        if (v < 0)
            return '0;
        if (v > 40'(dim - 1))
            return 16'(dim - 1);
        return v[15:0];
    endfunction

    assign accept   = (state == IDLE) && vif.i_dv;
    assign w_nonpos = vif.i_vertex[3][DATAWIDTH-1] || (vif.i_vertex[3] == '0);

    // The only nonzero dividend bit of 2^(2F) enters on the first step.
    assign rem_shift = {rem[RW-2:0], (div_cnt == CW'(DIV_STEPS - 1))};
    assign rem_ge    = rem_shift >= {1'b0, divisor};
    assign rem_next  = rem_ge ? (rem_shift - {1'b0, divisor}) : rem_shift;
    assign recip     = (quot > QW'(SAT_MAX)) ? RECIP_MAX : quot[DATAWIDTH-1:0];

    always_comb begin
        vx = {{(40-DATAWIDTH){nx[DATAWIDTH-1]}}, nx};
        vy = {{(40-DATAWIDTH){ny[DATAWIDTH-1]}}, ny};
        vx = ((vx + ONE_40) * HALF_W) >>> FRACBITS;
        vy = ((ONE_40 - vy) * HALF_H) >>> FRACBITS;
        clip_any = (nx > ONE_N) || (nx < -ONE_N) ||
                   (ny > ONE_N) || (ny < -ONE_N) ||
                   (nz > ONE_N) || (nz < -ONE_N);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (vif.i_dv) state_nxt = w_nonpos ? DONE : DIV;
            DIV:      if (div_cnt == '0) state_nxt = SCALE;
            SCALE:    state_nxt = VIEWPORT;
            VIEWPORT: state_nxt = DONE;
            DONE:     if (vif.i_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vif.o_ready = (state == IDLE);
        vif.o_dv    = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            rem       <= '0;
            quot      <= '0;
            divisor   <= '0;
            cx        <= '0;
            cy        <= '0;
            cz        <= '0;
            nx        <= '0;
            ny        <= '0;
            nz        <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            z_q       <= '0;
            clipped_q <= 1'b0;
        end else begin
            if (accept) begin
                cx      <= vif.i_vertex[0];
                cy      <= vif.i_vertex[1];
                cz      <= vif.i_vertex[2];
                divisor <= vif.i_vertex[3];
                div_cnt <= CW'(DIV_STEPS - 1);
                rem     <= '0;
                quot    <= '0;
                if (w_nonpos) begin
                    sx_q      <= '0;
                    sy_q      <= '0;
                    z_q       <= '0;
                    clipped_q <= 1'b1;
                end
            end
            if (state == DIV) begin
                rem     <= rem_next;
                quot    <= {quot[QW-2:0], rem_ge};
                div_cnt <= div_cnt - 1'b1;
            end
            if (state == SCALE) begin
                nx <= scale_sat(cx, recip);
                ny <= scale_sat(cy, recip);
                nz <= scale_sat(cz, recip);
            end
            if (state == VIEWPORT) begin
                sx_q      <= SXW'(vp_clamp(vx, SCREEN_WIDTH));
                sy_q      <= SYW'(vp_clamp(vy, SCREEN_HEIGHT));
                z_q       <= nz;
                clipped_q <= clip_any;
            end
        end
    end

    assign vif.o_sx      = sx_q;
    assign vif.o_sy      = sy_q;
    assign vif.o_z       = z_q;
    assign vif.o_clipped = clipped_q;
endmodule

// File: tb/tb_vertex_post_processor.sv
// Directed plus random bench for vertex_post_processor with an expected-result
// queue filled from an integer reference model.
module tb_vertex_post_processor;
    localparam int DW = 18;
    localparam int FB = 12;
    localparam int SW = 320;
    localparam int SH = 240;

    typedef struct {
        longint sx;
        longint sy;
        longint z;
        longint clipped;
        longint lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   ready_idle = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vertex_post_processor_if #(.DATAWIDTH(DW), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)) vif ();

    vertex_post_processor #(
        .DATAWIDTH(DW), .FRACBITS(FB), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vif(vif.slave)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic longint clampi(input longint v, input longint hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic exp_t model(input int x, input int y, input int z, input int w);
        exp_t e;
        longint recip, nx, ny, nz;
        if (w <= 0) begin
            e.sx = 0; e.sy = 0; e.z = 0; e.clipped = 1; e.lat = 1;
            return e;
        end
        recip = (longint'(1) << (2 * FB)) / longint'(w);
        if (recip > 131071) recip = 131071;
        nx = sat((longint'(x) * recip) >>> FB);
        ny = sat((longint'(y) * recip) >>> FB);
        nz = sat((longint'(z) * recip) >>> FB);
        e.sx = clampi(((nx + 4096) * (SW / 2)) >>> FB, SW - 1);
        e.sy = clampi(((4096 - ny) * (SH / 2)) >>> FB, SH - 1);
        e.z  = nz;
        e.clipped = (nx > 4096 || nx < -4096 || ny > 4096 || ny < -4096 ||
                     nz > 4096 || nz < -4096) ? 1 : 0;
        e.lat = 2 * FB + 4;
        return e;
    endfunction

    task automatic drive(input int x, input int y, input int z, input int w);
        @(negedge clk);
        vif.i_vertex[0] = DW'(x);
        vif.i_vertex[1] = DW'(y);
        vif.i_vertex[2] = DW'(z);
        vif.i_vertex[3] = DW'(w);
        vif.i_dv = 1'b1;
        check("o_ready_before_accept", vif.o_ready, 1);
        @(negedge clk);
        vif.i_dv = 1'b0;
    endtask

    task automatic collect(input int stall);
        exp_t e;
        int n = 1;
        while (!vif.o_dv && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!vif.o_dv) begin
            check("o_dv_timeout", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("o_sx", vif.o_sx, e.sx);
        check("o_sy", vif.o_sy, e.sy);
        check("o_z", $signed(vif.o_z), e.z);
        check("o_clipped", vif.o_clipped, e.clipped);
        for (int i = 0; i < stall; i++) begin
            vif.i_vertex[0] = DW'(i * 100);
            vif.i_vertex[3] = DW'(4096);
            vif.i_dv = 1'b1;
            @(negedge clk);
            check("stall_o_dv", vif.o_dv, 1);
            check("stall_o_ready", vif.o_ready, 0);
            check("stall_o_sx", vif.o_sx, e.sx);
            check("stall_o_z", $signed(vif.o_z), e.z);
        end
        vif.i_dv = 1'b0;
        vif.i_ready = 1'b1;
        @(negedge clk);
        check("post_xfer_o_dv", vif.o_dv, 0);
        check("post_xfer_o_ready", vif.o_ready, 1);
        vif.i_ready = ready_idle;
    endtask

    task automatic run(input int x, input int y, input int z, input int w, input int stall);
        sb.push_back(model(x, y, z, w));
        drive(x, y, z, w);
        collect(stall);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        vif.i_dv = 1'b0;
        vif.i_ready = 1'b0;
        vif.i_vertex = '0;
        repeat (3) @(negedge clk);
        check("rst_o_dv", vif.o_dv, 0);
        check("rst_o_sx", vif.o_sx, 0);
        check("rst_o_clipped", vif.o_clipped, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_o_ready", vif.o_ready, 1);

        run(2048, 0, 0, 4096, 0);
        run(4096, -4096, 1024, 8192, 0);
        run(0, 0, 0, 0, 0);
        run(100, 100, 100, -4096, 0);
        run(8192, 0, 0, 4096, 0);
        run(4096, 0, 0, 1, 0);

        // stalled result with vertices offered meanwhile; none may be captured
        run(-2048, 2048, -1024, 4096, 5);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (vif.o_dv) seen++;
        end
        check("no_extra_capture", seen, 0);

        // i_ready high when o_dv rises, back to back
        ready_idle = 1'b1;
        vif.i_ready = 1'b1;
        run(1024, 1024, 2048, 4096, 0);
        run(-8192, -512, 300, 12288, 0);
        ready_idle = 1'b0;
        vif.i_ready = 1'b0;

        // reset during the division discards the vertex
        drive(2048, 0, 0, 4096);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_o_dv", vif.o_dv, 0);
        check("midrst_o_sx", vif.o_sx, 0);
        check("midrst_o_sy", vif.o_sy, 0);
        check("midrst_o_z", vif.o_z, 0);
        check("midrst_o_clipped", vif.o_clipped, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (35) begin
            @(negedge clk);
            if (vif.o_dv) seen++;
        end
        check("discarded_no_o_dv", seen, 0);
        check("midrst_o_ready", vif.o_ready, 1);
        run(1000, -3000, -4000, 4096, 0);

        for (int i = 0; i < 6; i++) begin
            int x, y, z, w;
            x = int'($urandom_range(0, 16383)) - 8192;
            y = int'($urandom_range(0, 16383)) - 8192;
            z = int'($urandom_range(0, 16383)) - 8192;
            w = int'($urandom_range(1024, 16384));
            run(x, y, z, w, i % 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vertex_post_processor.md
VERTEX_POST_PROCESSOR -- requirements
Module: vertex_post_processor

Interface
REQ-001 Parameter DATAWIDTH, 18, signed fixed-point width of every coordinate.
REQ-002 Parameter FRACBITS, 12, fractional bits (1.0 = 2^FRACBITS = 4096).
REQ-003 Parameter SCREEN_WIDTH, 320, framebuffer width in pixels.
REQ-004 Parameter SCREEN_HEIGHT, 240, framebuffer height in pixels.
REQ-005 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 i_vertex  in  4 x DATAWIDTH signed  clip-space x,y,z,w from the vertex shader.
REQ-009 i_dv  in  1  i_vertex valid.
REQ-010 o_ready  out  1  block can accept a vertex.
REQ-011 i_ready  in  1  downstream accepts the current result.
REQ-012 o_sx  out  clog2(SCREEN_WIDTH)  screen x pixel.
REQ-013 o_sy  out  clog2(SCREEN_HEIGHT)  screen y pixel.
REQ-014 o_z  out  DATAWIDTH signed  NDC depth.
REQ-015 o_clipped  out  1  vertex rejected or outside the NDC cube.
REQ-016 o_dv  out  1  result valid.

Function
REQ-017 FSM states SHALL be IDLE, DIV, SCALE, VIEWPORT, DONE; o_ready SHALL be 1 only in IDLE.
REQ-018 Vertex accepted at edge k when IDLE and i_dv=1; i_vertex captured; i_dv ignored in every other state.
REQ-019 If captured w <= 0: next state DONE, o_clipped=1, o_sx=o_sy=o_z=0, so o_dv=1 from cycle k+1.
REQ-020 Otherwise DIV: unsigned restoring divider, one quotient bit per cycle, exactly 2*FRACBITS+1 cycles, recip = floor(2^(2*FRACBITS)/w).
REQ-021 recip SHALL saturate to 2^(DATAWIDTH-1)-1 when the quotient exceeds it.
REQ-022 SCALE (1 cycle): n_c = (c * recip) >>> FRACBITS for c in x,y,z; full-width product; arithmetic shift; saturate to signed DATAWIDTH.
REQ-023 VIEWPORT (1 cycle): sx = ((x_n + 2^F) * (SCREEN_WIDTH/2)) >> F; sy = ((2^F - y_n) * (SCREEN_HEIGHT/2)) >> F; each clamped to [0, dim-1].
REQ-024 o_clipped = 1 when |x_n|, |y_n| or |z_n| > 2^FRACBITS; the clamped sx/sy and o_z = z_n SHALL still be output.
REQ-025 Non-rejected latency: o_dv first high at cycle k+2*FRACBITS+4 (k+28 at defaults).
REQ-026 DONE: o_dv=1; outputs stable until i_ready=1; on o_dv && i_ready go IDLE, o_dv=0 and o_ready=1 next cycle.
REQ-027 i_ready=1 in the cycle o_dv rises SHALL complete the transfer in that cycle (no bubble beyond the IDLE cycle).
REQ-028 One vertex in flight at most; back-to-back throughput one vertex per 2*FRACBITS+5 cycles.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, o_dv=0, o_clipped=0, o_sx=o_sy=o_z=0, divider state cleared, o_ready=1 after rst released.
REQ-030 Reset mid-DIV/SCALE/DONE SHALL discard the in-flight vertex; no o_dv for it after release.

Verification
REQ-031 x=2048,y=0,z=0,w=4096 -> recip 4096, o_sx=240, o_sy=120, o_z=0, o_clipped=0, o_dv at k+28.
REQ-032 x=4096,y=-4096,z=1024,w=8192 -> recip 2048, o_sx=240, o_sy=180, o_z=512, o_clipped=0.
REQ-033 w=0 and w=-4096 -> o_dv at k+1, o_clipped=1, outputs 0; x=8192,w=4096 -> o_clipped=1, o_sx=319.
REQ-034 i_ready held 0 for 5 cycles in DONE, i_dv pulsed meanwhile -> outputs stable, o_ready=0, extra vertex not captured.
REQ-035 rst asserted at DIV cycle 10 -> all outputs 0 immediately, no o_dv; next vertex processed with correct 28-cycle latency.
REQ-036 w=1 -> recip saturates to 131071; x=4096 -> n_x saturates to 131071, o_clipped=1.
